ph_gen: RTL and testbench
=========================

PH_GEN -- requirements
Module: ph_gen

Interface
REQ-001 Parameter X_WIDTH, default 16, sample width of x1/x2 (signed).
REQ-002 Parameter FRAME_LENGTH, default 5, samples per frame (>=1).
REQ-003 Parameter PH_WIDTH, default 32, phase accumulator width.
REQ-004 Parameter LUT_BITS, default 8, sine table address width (2^LUT_BITS entries).
REQ-005 Port clk  input  1  single clock; all logic on posedge.
REQ-006 Port rstn  input  1  asynchronous active-low reset.
REQ-007 Port start  input  1  frame request, sampled only while IDLE.
REQ-008 Port amp  input  15  unsigned amplitude, 0..32767.
REQ-009 Port step  input  PH_WIDTH  phase increment per sample.
REQ-010 Port dph  input  PH_WIDTH  phase offset of channel 2 relative to channel 1.
REQ-011 Port gap  input  8  idle cycles inserted between consecutive samples.
REQ-012 Port o_vld  output  1  x1/x2 valid strobe, one cycle per sample.
REQ-013 Port x1  output  X_WIDTH  channel 1 sample, signed.
REQ-014 Port x2  output  X_WIDTH  channel 2 sample, signed.
REQ-015 Port busy  output  1  high while a frame is in progress.
REQ-016 Port done  output  1  one-cycle pulse coincident with the last sample's o_vld.

Function
REQ-017 FSM states: IDLE, EMIT, GAP.
REQ-018 IDLE: start=1 at an edge captures amp, step, dph, gap; clears phase accumulator and sample counter; moves to EMIT.
REQ-019 Later changes on amp/step/dph/gap do not affect a frame in progress.
REQ-020 EMIT: at the edge, registers sample k, asserts o_vld for one cycle, increments the counter and adds step to the accumulator.
REQ-021 First o_vld is high in the cycle after the edge that left IDLE (latency 1 cycle from start capture).
REQ-022 Sample k: p1 = k*step mod 2^PH_WIDTH, p2 = (p1 + dph) mod 2^PH_WIDTH.
REQ-023 Table index = top LUT_BITS bits of p1 and p2; lut[i] = round(32767*sin(2*pi*i/2^LUT_BITS)) as a 16-bit signed constant table.
REQ-024 x = (amp * lut[i]) computed as a 32-bit signed product, arithmetic shift right 15, then truncated to X_WIDTH.
REQ-025 After EMIT: gap=0 and samples remain -> stay in EMIT (back-to-back o_vld).
REQ-026 After EMIT: gap>0 and samples remain -> GAP for exactly gap cycles with o_vld=0, then EMIT.
REQ-027 After sample FRAME_LENGTH-1: assert done with its o_vld, wrap the counter to 0, return to IDLE (see REQ-033).
REQ-028 busy is 1 from the cycle after start capture through the cycle carrying done; 0 otherwise.
REQ-029 start while busy is ignored (no restart, no queuing).
REQ-030 x1/x2 hold their last values while o_vld=0.

Reset
REQ-031 rstn=0 asynchronously forces IDLE and zeroes o_vld, x1, x2, busy, done, the counter and the accumulator.
REQ-032 Reset asserted mid-frame aborts the frame with no done pulse; after release the block waits for a new start.

Configuration
REQ-033 Macro PH_GEN_CONT_EN defined: if start=1 on the done cycle, the next frame begins without returning to IDLE, using the gap rule between frames, keeping the accumulator (phase-continuous) and re-capturing amp/step/dph/gap; done pulses at every frame end.
REQ-034 Macro PH_GEN_CONT_EN undefined: always return to IDLE after done; a start held high begins the next frame one cycle later with the accumulator reset to 0.

Verification
REQ-035 Reset, amp=32767, step=2^30, dph=0, gap=0, start pulse -> 5 back-to-back o_vld; x1 = 0, 32766, 0, -32767, 0; done on the 5th; busy for 5 cycles.
REQ-036 Same as REQ-035 with dph=2^30 -> x2 = 32766, 0, -32767, 0, 32766; x1 unchanged.
REQ-037 gap=8, amp=100, step=2^30 -> o_vld pulses exactly 9 cycles apart, 5 pulses, x1 = 0, 99, 0, -100, 0.
REQ-038 start pulsed again mid-frame -> ignored; exactly FRAME_LENGTH samples; a new start after done produces a fresh frame starting at x1=0.
REQ-039 rstn low after the 2nd sample of a gap=8 frame -> all outputs 0 immediately; no done; next start yields a full 5-sample frame.
REQ-040 With PH_GEN_CONT_EN defined, start held high, step=2^30 -> 10 consecutive o_vld; x1 of sample 5 = 32766 (phase continuous); 2 done pulses.

Source files
------------

// File: rtl/ph_gen.sv
// Two-channel phase-offset sine frame generator: FRAME_LENGTH samples per start, with programmable inter-sample gap.
// Define PH_GEN_CONT_EN to chain frames phase-continuously when start is high on the done cycle.
module ph_gen #(
  parameter int X_WIDTH      = 16,
  parameter int FRAME_LENGTH = 5,
  parameter int PH_WIDTH     = 32,
  parameter int LUT_BITS     = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [14:0]                amp,
  input  logic [PH_WIDTH-1:0]        step,
  input  logic [PH_WIDTH-1:0]        dph,
  input  logic [7:0]                 gap,
  output logic                       o_vld,
  output logic signed [X_WIDTH-1:0]  x1,
  output logic signed [X_WIDTH-1:0]  x2,
  output logic                       busy,
  output logic                       done
);

  localparam int LUT_SIZE = 2 ** LUT_BITS;
  localparam int CNT_W    = (FRAME_LENGTH > 1) ? $clog2(FRAME_LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LENGTH - 1);
  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  // Table entry built at elaboration: fold into the first quadrant, Taylor-expand, round half away from zero.
  function automatic logic signed [15:0] sinEntry(input int idx);
    real theta, term, acc;
    int  half, quarter, j, r;
    logic neg;
    half    = LUT_SIZE / 2;
    quarter = LUT_SIZE / 4;
    neg     = (idx >= half);
    j       = idx % half;
    if (j > quarter) j = half - j;
    theta = 2.0 * PI * real'(j) / real'(LUT_SIZE);
    term  = theta;
    acc   = theta;
    for (int n = 1; n <= 11; n++) begin
      term = -term * theta * theta / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    r = $rtoi(32767.0 * acc + 0.5);
    if (r > 32767) r = 32767;
    return neg ? 16'(-r) : 16'(r);
  endfunction

  logic signed [15:0] w_lut [LUT_SIZE];

  for (genvar g = 0; g < LUT_SIZE; g++) begin : g_lut
    localparam logic signed [15:0] C_ENTRY = sinEntry(g);
    assign w_lut[g] = C_ENTRY;
  end

  state_t              r_state;
  logic [14:0]         r_amp;
  logic [PH_WIDTH-1:0] r_step;
  logic [PH_WIDTH-1:0] r_dph;
  logic [7:0]          r_gap;
  logic [7:0]          r_gapCnt;
  logic [PH_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_capture;
  logic                w_contNow;
  logic                w_emit;
  logic [14:0]         w_srcAmp;
  logic [PH_WIDTH-1:0] w_srcStep;
  logic [PH_WIDTH-1:0] w_srcDph;
  logic [PH_WIDTH-1:0] w_srcAcc;
  logic [7:0]          w_srcGap;
  logic [CNT_W-1:0]    w_srcCnt;
  logic [LUT_BITS-1:0] w_idx1;
  logic [LUT_BITS-1:0] w_idx2;
  logic signed [31:0]  w_prod1;
  logic signed [31:0]  w_prod2;

  assign w_capture = (r_state == IDLE) && start;

`ifdef PH_GEN_CONT_EN
  assign w_contNow = w_capture && done;
`else
  assign w_contNow = 1'b0;
`endif

  // The capturing edge already emits sample 0 from the live inputs, giving one cycle of latency.
  assign w_emit    = (r_state == EMIT) || (w_capture && !(w_contNow && (r_gap != 8'd0)));
  assign w_srcAmp  = w_capture ? amp  : r_amp;
  assign w_srcStep = w_capture ? step : r_step;
  assign w_srcDph  = w_capture ? dph  : r_dph;
  assign w_srcGap  = w_capture ? gap  : r_gap;
  assign w_srcAcc  = (w_capture && !w_contNow) ? '0 : r_acc;
  assign w_srcCnt  = w_capture ? '0 : r_cnt;

  assign w_idx1  = w_srcAcc[PH_WIDTH-1 -: LUT_BITS];
  assign w_idx2  = LUT_BITS'((w_srcAcc + w_srcDph) >> (PH_WIDTH - LUT_BITS));
  assign w_prod1 = $signed({17'd0, w_srcAmp}) * $signed({{16{w_lut[w_idx1][15]}}, w_lut[w_idx1]});
  assign w_prod2 = $signed({17'd0, w_srcAmp}) * $signed({{16{w_lut[w_idx2][15]}}, w_lut[w_idx2]});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_amp    <= '0;
      r_step   <= '0;
      r_dph    <= '0;
      r_gap    <= '0;
      r_gapCnt <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      o_vld    <= 1'b0;
      x1       <= '0;
      x2       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_amp  <= amp;
        r_step <= step;
        r_dph  <= dph;
        r_gap  <= gap;
      end
      if (w_emit) begin
        o_vld <= 1'b1;
        busy  <= 1'b1;
        x1    <= X_WIDTH'(w_prod1 >>> 15);
        x2    <= X_WIDTH'(w_prod2 >>> 15);
        r_acc <= w_srcAcc + w_srcStep;
        if (w_srcCnt == LAST_CNT) begin
          done    <= 1'b1;
          r_cnt   <= '0;
          r_state <= IDLE;
        end else begin
          done     <= 1'b0;
          r_cnt    <= w_srcCnt + 1'b1;
          r_gapCnt <= w_srcGap;
          r_state  <= (w_srcGap == 8'd0) ? EMIT : GAP;
        end
      end else begin
        o_vld <= 1'b0;
        done  <= 1'b0;
        case (r_state)
          IDLE: begin
            // A chained frame with a nonzero gap spends this edge as its first gap cycle.
            busy <= w_contNow;
            if (w_contNow) begin
              r_cnt    <= '0;
              r_gapCnt <= r_gap - 8'd1;
              r_state  <= (r_gap == 8'd1) ? EMIT : GAP;
            end
          end
          GAP: begin
            if (r_gapCnt <= 8'd1) r_state <= EMIT;
            else                  r_gapCnt <= r_gapCnt - 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ph_gen.sv
// Bench for ph_gen: sine-table scoreboard model plus directed frames with hand-computed sample values.
// Expectations for the held-start frame pair follow PH_GEN_CONT_EN when it is defined.
module tb_ph_gen;

  localparam real PI = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               start = 1'b0;
  logic [14:0]        amp = '0;
  logic [31:0]        step = '0;
  logic [31:0]        dph = '0;
  logic [7:0]         gap = '0;
  logic               o_vld;
  logic signed [15:0] x1;
  logic signed [15:0] x2;
  logic               busy;
  logic               done;

  ph_gen dut (
    .clk  (clk),
    .rstn (rstn),
    .start(start),
    .amp  (amp),
    .step (step),
    .dph  (dph),
    .gap  (gap),
    .o_vld(o_vld),
    .x1   (x1),
    .x2   (x2),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] e1;
    logic signed [15:0] e2;
    logic               eDone;
  } sbEntry_t;

  sbEntry_t expQ[$];
  int vldCyc[$];
  int obsX1[$];
  int obsX2[$];
  int vecCount = 0;
  int missCount = 0;
  int cyc = 0;
  int doneCount = 0;
  int busyCycles = 0;

`ifdef PH_GEN_CONT_EN
  localparam int HELD_X1_S5 = 32766;
  localparam int HELD_X2_S5 = 0;
  localparam int HELD_K0 = 5;
`else
  localparam int HELD_X1_S5 = 0;
  localparam int HELD_X2_S5 = 32766;
  localparam int HELD_K0 = 0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int lutRef(input int idx);
    real v;
    v = 32767.0 * $sin(2.0 * PI * real'(idx) / 256.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic logic signed [15:0] modelX(input int a, input logic [31:0] ph);
    int l;
    int p;
    l = lutRef(int'(ph[31:24]));
    p = a * l;
    return 16'(p >>> 15);
  endfunction

  task automatic pushFrame(input int a, input logic [31:0] s, input logic [31:0] d, input int k0);
    logic [31:0] p1;
    logic [31:0] p2;
    sbEntry_t e;
    for (int k = 0; k < 5; k++) begin
      p1 = 32'(k0 + k) * s;
      p2 = p1 + d;
      e.e1 = modelX(a, p1);
      e.e2 = modelX(a, p2);
      e.eDone = (k == 4);
      expQ.push_back(e);
    end
  endtask

  // Every valid sample is checked against the model queue; observations are kept for timing checks.
  always @(negedge clk) begin : compareProc
    sbEntry_t e;
    if (rstn) begin
      if (busy) busyCycles++;
      if (done) doneCount++;
      if (o_vld) begin
        vldCyc.push_back(cyc);
        obsX1.push_back(int'(x1));
        obsX2.push_back(int'(x2));
        if (expQ.size() == 0) begin
          checkOutput("unexpected_vld", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("x1", int'(x1), int'(e.e1));
          checkOutput("x2", int'(x2), int'(e.e2));
          checkOutput("done", int'(done), int'(e.eDone));
        end
      end else if (done) begin
        checkOutput("done_without_vld", 1, 0);
      end
    end
  end

  task automatic resetObs();
    vldCyc.delete();
    obsX1.delete();
    obsX2.delete();
    doneCount = 0;
    busyCycles = 0;
  endtask

  task automatic applyStimulus(input int a, input logic [31:0] s, input logic [31:0] d, input logic [7:0] g);
    @(posedge clk);
    #1;
    amp = 15'(a);
    step = s;
    dph = d;
    gap = g;
    start = 1'b1;
    pushFrame(a, s, d, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    amp = 15'($urandom);
    step = $urandom;
    dph = $urandom;
    gap = 8'($urandom);
  endtask

  task automatic waitDone(input string name, input int n, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (doneCount >= n) break;
    end
    checkOutput({name, "_done_seen"}, int'(doneCount >= n), 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic waitVld(input string name, input int n, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (vldCyc.size() >= n) break;
    end
    checkOutput({name, "_vld_seen"}, int'(vldCyc.size() >= n), 1);
  endtask

  task automatic checkFrame(input string name, input int expN, input int spacing);
    checkOutput({name, "_vld_count"}, vldCyc.size(), expN);
    for (int i = 1; i < vldCyc.size(); i++)
      checkOutput($sformatf("%s_spacing[%0d]", name, i), vldCyc[i] - vldCyc[i-1], spacing);
    checkOutput({name, "_queue_left"}, expQ.size(), 0);
  endtask

  task automatic checkList(input string name, input int obs[$], input int expv[5]);
    int act;
    for (int i = 0; i < 5; i++) begin
      act = (i < obs.size()) ? obs[i] : 99999;
      checkOutput($sformatf("%s[%0d]", name, i), act, expv[i]);
    end
  endtask

  task automatic checkIdleZero(input string name);
    checkOutput({name, "_o_vld"}, int'(o_vld), 0);
    checkOutput({name, "_x1"}, int'(x1), 0);
    checkOutput({name, "_x2"}, int'(x2), 0);
    checkOutput({name, "_busy"}, int'(busy), 0);
    checkOutput({name, "_done"}, int'(done), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkIdleZero("reset");
    rstn = 1'b1;

    $display("[TB] full-scale quarter-step frame");
    resetObs();
    applyStimulus(32767, 32'h4000_0000, 32'h0, 8'd0);
    waitDone("fs", 1, 100);
    checkFrame("fs", 5, 1);
    checkOutput("fs_busy_cycles", busyCycles, 5);
    checkOutput("fs_done_count", doneCount, 1);
    checkList("fs_x1", obsX1, '{0, 32766, 0, -32767, 0});
    checkList("fs_x2", obsX2, '{0, 32766, 0, -32767, 0});

    $display("[TB] quadrature offset frame");
    resetObs();
    applyStimulus(32767, 32'h4000_0000, 32'h4000_0000, 8'd0);
    waitDone("quad", 1, 100);
    checkFrame("quad", 5, 1);
    checkList("quad_x1", obsX1, '{0, 32766, 0, -32767, 0});
    checkList("quad_x2", obsX2, '{32766, 0, -32767, 0, 32766});

    $display("[TB] gapped frame");
    resetObs();
    applyStimulus(100, 32'h4000_0000, 32'h0, 8'd8);
    waitDone("gap8", 1, 200);
    checkFrame("gap8", 5, 9);
    checkOutput("gap8_done_count", doneCount, 1);
    checkList("gap8_x1", obsX1, '{0, 99, 0, -100, 0});

    $display("[TB] start during frame");
    resetObs();
    applyStimulus(5000, 32'h1234_5678, 32'h4000_0000, 8'd2);
    waitVld("mid", 2, 50);
    @(posedge clk);
    #1;
    start = 1'b1;
    amp = 15'd1234;
    step = 32'h0100_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("mid", 1, 100);
    checkFrame("mid", 5, 3);
    checkOutput("mid_done_count", doneCount, 1);
    repeat (3) @(posedge clk);
    resetObs();
    applyStimulus(20000, 32'h2000_0000, 32'h1000_0000, 8'd1);
    waitDone("fresh", 1, 100);
    checkFrame("fresh", 5, 2);
    checkOutput("fresh_x1_s0", (obsX1.size() > 0) ? obsX1[0] : 99999, 0);
    checkOutput("fresh_x1_s2", (obsX1.size() > 2) ? obsX1[2] : 99999, 19999);

    $display("[TB] reset during frame");
    resetObs();
    applyStimulus(3000, 32'h4000_0000, 32'h0, 8'd8);
    waitVld("abort", 2, 50);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checkIdleZero("abort");
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (20) @(posedge clk);
    checkOutput("abort_done_count", doneCount, 0);
    checkOutput("abort_vld_count", vldCyc.size(), 2);
    resetObs();
    applyStimulus(3000, 32'h4000_0000, 32'h0, 8'd8);
    waitDone("after_abort", 1, 200);
    checkFrame("after_abort", 5, 9);
    checkList("after_abort_x1", obsX1, '{0, 2999, 0, -3000, 0});

    $display("[TB] start held across two frames");
    resetObs();
    @(posedge clk);
    #1;
    amp = 15'd32767;
    step = 32'h4000_0000;
    dph = 32'h4000_0000;
    gap = 8'd0;
    start = 1'b1;
    pushFrame(32767, 32'h4000_0000, 32'h4000_0000, 0);
    pushFrame(32767, 32'h4000_0000, 32'h4000_0000, HELD_K0);
    repeat (7) @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("held", 2, 100);
    checkFrame("held", 10, 1);
    checkOutput("held_done_count", doneCount, 2);
    checkOutput("held_busy_cycles", busyCycles, 10);
    checkOutput("held_x1_s5", (obsX1.size() > 5) ? obsX1[5] : 99999, HELD_X1_S5);
    checkOutput("held_x2_s5", (obsX2.size() > 5) ? obsX2[5] : 99999, HELD_X2_S5);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
